ifetch_ctrl: RTL

Fetch sequencer for the combinational instruction memory. Drives the fetch PC into the memory and selects the next PC, either sequential or the YAGS-predicted branch target. Buffers fetched instructions in a small queue toward decode using a valid/ready handshake. Handles execute-stage redirects by flushing the queue and restarting fetch.

---
 rtl/ifetch_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: drives the instruction-memory PC, picks sequential or predicted-taken
// next PC, and buffers fetched instructions in a small valid/ready queue toward decode.
module ifetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic [XLEN-1:0]          pc_out,
    input  logic [XLEN-1:0]          instruction_in,
    input  logic                     branch_check_in,
    input  logic [XLEN-1:0]          imm_yags_in,
    input  logic                     pred_taken,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic                     out_pred_taken,
    output logic [XLEN-1:0]          out_pred_target,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];
    logic            mem_take  [DEPTH];
    logic [XLEN-1:0] mem_tgt   [DEPTH];

    logic            pop, push, take;
    logic [XLEN-1:0] nxt;

    // Redirect target is word-aligned; the low bits are deliberately dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = fetch_en & ~redirect_valid & ((cnt_q < CW'(DEPTH)) | pop);
    assign take      = branch_check_in & pred_taken;
    assign nxt       = take ? (pc_q + imm_yags_in) : (pc_q + XLEN'(4));

    always_comb begin
        pc_d  = pc_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (redirect_valid) begin
            pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                pc_d = nxt;
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: it is only visible while the count says it is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_q]    <= pc_q;
            mem_instr[wr_q] <= instruction_in;
            mem_take[wr_q]  <= take;
            mem_tgt[wr_q]   <= nxt;
        end
    end

    always_comb begin
        out_instr       = '0;
        out_pc          = '0;
        out_pred_taken  = 1'b0;
        out_pred_target = '0;
        if (out_valid) begin
            out_instr       = mem_instr[rd_q];
            out_pc          = mem_pc[rd_q];
            out_pred_taken  = mem_take[rd_q];
            out_pred_target = mem_tgt[rd_q];
        end
    end

    assign pc_out  = pc_q;
    assign q_count = cnt_q;

endmodule
